// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch/jump squash,
// and saturating stall/flush event counters.
module id_ex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid_ip,
  input  logic [6:0]        id_instr_opcode_ip,
  input  logic [4:0]        id_rs1_ip,
  input  logic [4:0]        id_rs2_ip,
  input  logic [4:0]        id_rd_ip,
  input  logic [DATA_W-1:0] id_rs1_data_ip,
  input  logic [DATA_W-1:0] id_rs2_data_ip,
  input  logic [DATA_W-1:0] id_imm_ip,
  input  logic [DATA_W-1:0] id_pc_ip,
  input  logic [1:0]        id_wb_mux_ip,
  input  logic [CTRL_W-1:0] id_ctrl_ip,
  input  logic              ex_flush_ip,
  input  logic              hold_ip,
  output logic              ex_valid_op,
  output logic [6:0]        ex_opcode_op,
  output logic [4:0]        ex_rs1_op,
  output logic [4:0]        ex_rs2_op,
  output logic [4:0]        ex_rd_op,
  output logic [DATA_W-1:0] ex_rs1_data_op,
  output logic [DATA_W-1:0] ex_rs2_data_op,
  output logic [DATA_W-1:0] ex_imm_op,
  output logic [DATA_W-1:0] ex_pc_op,
  output logic [1:0]        ex_wb_mux_op,
  output logic [CTRL_W-1:0] ex_ctrl_op,
  output logic              stall_op,
  output logic [CNT_W-1:0]  stall_cnt_op,
  output logic [CNT_W-1:0]  flush_cnt_op
);

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [1:0] NO_WRITEBACK  = 2'b00;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic uses_rs1;
  logic uses_rs2;
  logic load_use;
  logic pipe_en;
  logic load_bubble;
  logic [1:0] cnt_inc;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_instr_opcode_ip)
      OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = ex_valid_op && (ex_opcode_op == OPCODE_LOAD) && (ex_rd_op != 5'd0) &&
                    id_valid_ip && ((uses_rs1 && (id_rs1_ip == ex_rd_op)) ||
                                    (uses_rs2 && (id_rs2_ip == ex_rd_op)));

  assign stall_op = load_use && !ex_flush_ip && !hold_ip;

  // Flush overrides hold; an invalid ID slot is loaded as a bubble so stale
  // indices can never match in the forwarding unit.
  assign pipe_en     = ex_flush_ip || !hold_ip;
  assign load_bubble = ex_flush_ip || load_use || !id_valid_ip;

  always_ff @(posedge clk) begin
    if (!reset || (pipe_en && load_bubble)) begin
      ex_valid_op    <= 1'b0;
      ex_opcode_op   <= 7'b0;
      ex_rs1_op      <= 5'd0;
      ex_rs2_op      <= 5'd0;
      ex_rd_op       <= 5'd0;
      ex_rs1_data_op <= '0;
      ex_rs2_data_op <= '0;
      ex_imm_op      <= '0;
      ex_pc_op       <= '0;
      ex_wb_mux_op   <= NO_WRITEBACK;
      ex_ctrl_op     <= '0;
    end else if (pipe_en) begin
      ex_valid_op    <= 1'b1;
      ex_opcode_op   <= id_instr_opcode_ip;
      ex_rs1_op      <= id_rs1_ip;
      ex_rs2_op      <= id_rs2_ip;
      ex_rd_op       <= id_rd_ip;
      ex_rs1_data_op <= id_rs1_data_ip;
      ex_rs2_data_op <= id_rs2_data_ip;
      ex_imm_op      <= id_imm_ip;
      ex_pc_op       <= id_pc_ip;
      ex_wb_mux_op   <= id_wb_mux_ip;
      ex_ctrl_op     <= id_ctrl_ip;
    end
  end

  // Counter 0 tracks load-use bubbles, counter 1 tracks flush bubbles.
  assign cnt_inc[0] = stall_op;
  assign cnt_inc[1] = ex_flush_ip;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end
      end
    end
  endgenerate

  assign stall_cnt_op = gen_cnt[0].cnt_reg;
  assign flush_cnt_op = gen_cnt[1].cnt_reg;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed plus randomized bench for id_ex_hazard_reg, checked against a
// transaction-level model of the ID/EX slot and the two event counters.
module tb_id_ex_hazard_reg;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NW = 4;
  localparam int CNT_MAX = 15;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          id_valid;
  logic [6:0]    id_opc;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic [DW-1:0] id_d1, id_d2, id_imm, id_pc;
  logic [1:0]    id_wb;
  logic [CW-1:0] id_ctrl;
  logic          flush, hold;

  logic          ex_valid;
  logic [6:0]    ex_opc;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic [DW-1:0] ex_d1, ex_d2, ex_imm, ex_pc;
  logic [1:0]    ex_wb;
  logic [CW-1:0] ex_ctrl;
  logic          stall;
  logic [NW-1:0] stall_cnt, flush_cnt;

  id_ex_hazard_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset), .id_valid_ip(id_valid), .id_instr_opcode_ip(id_opc),
    .id_rs1_ip(id_rs1), .id_rs2_ip(id_rs2), .id_rd_ip(id_rd),
    .id_rs1_data_ip(id_d1), .id_rs2_data_ip(id_d2), .id_imm_ip(id_imm), .id_pc_ip(id_pc),
    .id_wb_mux_ip(id_wb), .id_ctrl_ip(id_ctrl), .ex_flush_ip(flush), .hold_ip(hold),
    .ex_valid_op(ex_valid), .ex_opcode_op(ex_opc), .ex_rs1_op(ex_rs1), .ex_rs2_op(ex_rs2),
    .ex_rd_op(ex_rd), .ex_rs1_data_op(ex_d1), .ex_rs2_data_op(ex_d2), .ex_imm_op(ex_imm),
    .ex_pc_op(ex_pc), .ex_wb_mux_op(ex_wb), .ex_ctrl_op(ex_ctrl), .stall_op(stall),
    .stall_cnt_op(stall_cnt), .flush_cnt_op(flush_cnt)
  );

  typedef struct packed {
    logic          valid;
    logic [6:0]    opc;
    logic [4:0]    rs1, rs2, rd;
    logic [DW-1:0] d1, d2, imm, pc;
    logic [1:0]    wb;
    logic [CW-1:0] ctrl;
  } slot_t;

  slot_t m_slot;
  int    m_sc, m_fc;
  bit    last_stall;
  int    checks = 0;
  int    failures = 0;
  logic [6:0] opc_tab [8] = '{OP, OPIMM, LOAD, STORE, BRANCH, JALR, LUI, JAL};

  function automatic bit reads_rs1(logic [6:0] o);
    return o inside {OP, OPIMM, LOAD, STORE, BRANCH, JALR};
  endfunction

  function automatic bit reads_rs2(logic [6:0] o);
    return o inside {OP, STORE, BRANCH};
  endfunction

  // A load in EX whose destination is read by the valid instruction in ID.
  function automatic bit model_hazard();
    if (!(m_slot.valid && m_slot.opc == LOAD && m_slot.rd != 5'd0 && id_valid)) return 1'b0;
    return (reads_rs1(id_opc) && id_rs1 == m_slot.rd) || (reads_rs2(id_opc) && id_rs2 == m_slot.rd);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [6:0] o, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd);
    id_valid = v; id_opc = o; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_d1 = $urandom; id_d2 = $urandom; id_imm = $urandom; id_pc = $urandom;
    id_wb = 2'($urandom_range(0, 3)); id_ctrl = 16'($urandom);
    flush = 1'b0; hold = 1'b0; reset = 1'b1;
  endtask

  task automatic drive_random();
    drive($urandom_range(0, 7) != 0, opc_tab[$urandom_range(0, 7)],
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    flush = ($urandom_range(0, 9) == 0);
    hold  = ($urandom_range(0, 7) == 0);
    reset = ($urandom_range(0, 49) != 0);
  endtask

  // One cycle: check the combinational stall, advance model and DUT, check state.
  task automatic step();
    bit    hz;
    slot_t cap;
    #1;
    hz = model_hazard();
    last_stall = hz && !flush && !hold;
    check("stall_op", 64'(stall), 64'(last_stall));
    @(posedge clk);
    cap = '{id_valid, id_opc, id_rs1, id_rs2, id_rd, id_d1, id_d2, id_imm, id_pc, id_wb, id_ctrl};
    if (!reset) begin
      m_slot = '0; m_sc = 0; m_fc = 0;
    end else if (flush) begin
      m_slot = '0; m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : CNT_MAX;
    end else if (!hold) begin
      if (hz) begin
        m_slot = '0; m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
      end else begin
        m_slot = id_valid ? cap : '0;
      end
    end
    #1;
    check("ex_valid", 64'(ex_valid), 64'(m_slot.valid));
    check("ex_opcode", 64'(ex_opc), 64'(m_slot.opc));
    check("ex_rs1", 64'(ex_rs1), 64'(m_slot.rs1));
    check("ex_rs2", 64'(ex_rs2), 64'(m_slot.rs2));
    check("ex_rd", 64'(ex_rd), 64'(m_slot.rd));
    check("ex_rs1_data", 64'(ex_d1), 64'(m_slot.d1));
    check("ex_rs2_data", 64'(ex_d2), 64'(m_slot.d2));
    check("ex_imm", 64'(ex_imm), 64'(m_slot.imm));
    check("ex_pc", 64'(ex_pc), 64'(m_slot.pc));
    check("ex_wb_mux", 64'(ex_wb), 64'(m_slot.wb));
    check("ex_ctrl", 64'(ex_ctrl), 64'(m_slot.ctrl));
    check("stall_cnt", 64'(stall_cnt), 64'(m_sc));
    check("flush_cnt", 64'(flush_cnt), 64'(m_fc));
    $display("step t=%0t rst=%0b v=%0b opc=%h rs1=%0d rs2=%0d rd=%0d fl=%0b hd=%0b stall=%0b scnt=%0d fcnt=%0d",
             $time, reset, id_valid, id_opc, id_rs1, id_rs2, id_rd, flush, hold,
             last_stall, stall_cnt, flush_cnt);
    @(negedge clk);
  endtask

  initial begin
    m_slot = '0; m_sc = 0; m_fc = 0; last_stall = 1'b0;
    drive_random();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held with random ID traffic.
    repeat (2) begin
      drive_random(); reset = 1'b0; step();
    end
    check("reset_wb_none", 64'(ex_wb), 64'(0));
    check("reset_valid", 64'(ex_valid), 64'(0));

    // Pass-through: OP x3 = x1 + x2 at pc 0x100.
    drive(1, OP, 5'd1, 5'd2, 5'd3); id_pc = 32'h100; step();
    check("pass_opcode", 64'(ex_opc), 64'(OP));
    check("pass_rd", 64'(ex_rd), 64'(3));
    check("pass_pc", 64'(ex_pc), 64'h100);
    check("pass_valid", 64'(ex_valid), 64'(1));

    // Load-use: LOAD x5 then OP x6 = x5 + x7 stalls one cycle.
    drive(1, LOAD, 5'd1, 5'd0, 5'd5); step();
    drive(1, OP, 5'd5, 5'd7, 5'd6); step();
    check("lu_stall", 64'(last_stall), 64'(1));
    check("lu_bubble", 64'(ex_valid), 64'(0));
    step();
    check("lu_restall", 64'(last_stall), 64'(0));
    check("lu_captured_rd", 64'(ex_rd), 64'(6));
    check("lu_stall_cnt", 64'(stall_cnt), 64'(1));

    // No false stalls: load to x0, and an unused rs2 field matching.
    drive(1, LOAD, 5'd1, 5'd0, 5'd0); step();
    drive(1, OP, 5'd0, 5'd0, 5'd4); step();
    check("nofalse_x0", 64'(last_stall), 64'(0));
    drive(1, LOAD, 5'd1, 5'd0, 5'd5); step();
    drive(1, OPIMM, 5'd4, 5'd5, 5'd4); step();
    check("nofalse_rs2", 64'(last_stall), 64'(0));

    // Flush together with a load-use hazard.
    drive(1, LOAD, 5'd1, 5'd0, 5'd5); step();
    drive(1, OP, 5'd5, 5'd7, 5'd6); flush = 1'b1; step();
    check("flush_stall", 64'(last_stall), 64'(0));
    check("flush_cnt1", 64'(flush_cnt), 64'(1));
    check("flush_scnt", 64'(stall_cnt), 64'(1));

    // Hold freezes the slot.
    drive(1, OP, 5'd1, 5'd2, 5'd3); step();
    drive(1, OPIMM, 5'd9, 5'd9, 5'd9); hold = 1'b1; step();
    check("hold_rd", 64'(ex_rd), 64'(3));

    // Counter saturation.
    for (int i = 0; i < 18; i++) begin
      drive(1, LOAD, 5'd1, 5'd0, 5'd5); step();
      drive(1, BRANCH, 5'd2, 5'd5, 5'd0); step();
      step();
    end
    check("sat_stall_cnt", 64'(stall_cnt), 64'(CNT_MAX));
    for (int i = 0; i < 18; i++) begin
      drive_random(); reset = 1'b1; flush = 1'b1; step();
    end
    check("sat_flush_cnt", 64'(flush_cnt), 64'(CNT_MAX));

    // Reset asserted while a stall is pending.
    drive(1, LOAD, 5'd1, 5'd0, 5'd5); step();
    drive(1, OP, 5'd5, 5'd7, 5'd6); reset = 1'b0; step();
    check("rst_stall_before", 64'(last_stall), 64'(1));
    check("rst_cleared_cnt", 64'(stall_cnt), 64'(0));
    reset = 1'b1; step();
    check("rst_stall_after", 64'(last_stall), 64'(0));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive_random(); step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
